enemyshell_flight: RTL

Responder end of the enemy fire handshake. Accepts the level fire request (enemyshell_state) from one enemy tank controller and launches a shell from the tank's tile in the tank's facing direction. Steps the shell one grid tile per move tick, detects a hit on the player tank or the grid edge, and reports busy status back on enemyshell_state_feedback. One instance per enemy tank; shell coordinates go to the renderer.

---
 rtl/enemyshell_flight_pkg.sv | 24 ++
 rtl/enemyshell_flight_if.sv | 20 ++
 rtl/enemyshell_flight_shell_step.sv | 26 ++
 rtl/enemyshell_flight.sv | 119 +++++++++++
 4 files changed

// File: rtl/enemyshell_flight_pkg.sv
// Shared encodings and grid limits for the tank shell controllers.
// Pure declarations: no logic, no latency.
package enemyshell_flight_pkg;

    localparam logic [4:0] X_MAX   = 5'd24;
    localparam logic [4:0] Y_MAX   = 5'd20;
    localparam logic [4:0] PARK_XY = 5'd31;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLY     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    function automatic logic on_grid(input logic [4:0] x, input logic [4:0] y);
        return (x <= X_MAX) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/enemyshell_flight_if.sv
// Fire handshake between an enemy tank controller (master) and its shell block (slave).
// Level request with busy feedback; the request is held by the tank, no backpressure.
interface enemyshell_flight_if;
    logic       enemyshell_state;
    logic       tank_state;
    logic [4:0] enemytank_xpos;
    logic [4:0] enemytank_ypos;
    logic [1:0] tank_dir;
    logic       enemyshell_state_feedback;

    modport master (
        output enemyshell_state, tank_state, enemytank_xpos, enemytank_ypos, tank_dir,
        input  enemyshell_state_feedback
    );

    modport slave (
        input  enemyshell_state, tank_state, enemytank_xpos, enemytank_ypos, tank_dir,
        output enemyshell_state_feedback
    );
endinterface

// File: rtl/enemyshell_flight_shell_step.sv
// Next tile for a shell moving one step in dir, flagging moves that would leave the grid.
// Combinational, zero latency; no handshake.
module enemyshell_flight_shell_step
    import enemyshell_flight_pkg::*;
(
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [1:0] dir,
    output logic [4:0] next_x,
    output logic [4:0] next_y,
    output logic       off_edge
);

    always_comb begin
        next_x   = x;
        next_y   = y;
        off_edge = 1'b0;
        case (dir)
            DIR_UP:    if (y == 5'd0)  off_edge = 1'b1; else next_y = y - 5'd1;
            DIR_DOWN:  if (y == Y_MAX) off_edge = 1'b1; else next_y = y + 5'd1;
            DIR_LEFT:  if (x == 5'd0)  off_edge = 1'b1; else next_x = x - 5'd1;
            default:   if (x == X_MAX) off_edge = 1'b1; else next_x = x + 5'd1;
        endcase
    end

endmodule

// File: rtl/enemyshell_flight.sv
// Enemy shell launcher/flight: launches from the tank tile, steps per tick, detects player hit or edge.
// Launch visible 1 clk after request; request is a held level, feedback marks busy (no backpressure).
module enemyshell_flight
    import enemyshell_flight_pkg::*;
#(
    parameter int HIT_CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 step_tick,
    input  logic [4:0]           mytank_xpos,
    input  logic [4:0]           mytank_ypos,
    input  logic                 item_frozen,
    enemyshell_flight_if.slave   fire,
    output logic [4:0]           enemyshell_x,
    output logic [4:0]           enemyshell_y,
    output logic [1:0]           enemyshell_dir,
    output logic                 hit_mytank,
    output logic [HIT_CNT_W-1:0] hit_cnt
);

    state_t state, state_nxt;

    logic [4:0]           x_nxt, y_nxt;
    logic [1:0]           dir_nxt;
    logic                 hit_nxt;
    logic [HIT_CNT_W-1:0] cnt_nxt;
    logic                 feedback_q;

    logic [4:0] step_x, step_y;
    logic       off_edge;
    logic       launch, hit_now, move_now, off_grid;

    enemyshell_flight_shell_step u_step (
        .x        (enemyshell_x),
        .y        (enemyshell_y),
        .dir      (enemyshell_dir),
        .next_x   (step_x),
        .next_y   (step_y),
        .off_edge (off_edge)
    );

    assign launch   = (state == ST_IDLE) && fire.enemyshell_state && fire.tank_state;
    assign hit_now  = (state == ST_FLY) && (enemyshell_x == mytank_xpos) && (enemyshell_y == mytank_ypos);
    assign move_now = step_tick && !item_frozen;
    // A shell launched from an off-grid tank tile must die without ever moving.
    assign off_grid = !on_grid(enemyshell_x, enemyshell_y);

    always_ff @(posedge clk) begin
        if (rst || !enable) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (launch) state_nxt = ST_FLY;
            ST_FLY:     if (hit_now || off_grid || (move_now && off_edge)) state_nxt = ST_RECOVER;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        x_nxt   = enemyshell_x;
        y_nxt   = enemyshell_y;
        dir_nxt = enemyshell_dir;
        hit_nxt = 1'b0;
        cnt_nxt = hit_cnt;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    x_nxt   = fire.enemytank_xpos;
                    y_nxt   = fire.enemytank_ypos;
                    dir_nxt = fire.tank_dir;
                end
            end
            ST_FLY: begin
                if (hit_now) begin
                    hit_nxt = 1'b1;
                    cnt_nxt = (&hit_cnt) ? hit_cnt : hit_cnt + HIT_CNT_W'(1);
                    x_nxt   = PARK_XY;
                    y_nxt   = PARK_XY;
                end else if (state_nxt == ST_RECOVER) begin
                    x_nxt = PARK_XY;
                    y_nxt = PARK_XY;
                end else if (move_now) begin
                    x_nxt = step_x;
                    y_nxt = step_y;
                end
            end
            default: begin
                x_nxt = PARK_XY;
                y_nxt = PARK_XY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            enemyshell_x   <= PARK_XY;
            enemyshell_y   <= PARK_XY;
            enemyshell_dir <= DIR_UP;
            hit_mytank     <= 1'b0;
            hit_cnt        <= '0;
            feedback_q     <= 1'b0;
        end else begin
            enemyshell_x   <= x_nxt;
            enemyshell_y   <= y_nxt;
            enemyshell_dir <= dir_nxt;
            hit_mytank     <= hit_nxt;
            hit_cnt        <= cnt_nxt;
            feedback_q     <= (state_nxt == ST_FLY);
        end
    end

    assign fire.enemyshell_state_feedback = feedback_q;

endmodule
